if_fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer for the IF stage.
- Owns the fetch PC and drives a single-outstanding Wishbone-style instruction port.
- Buffers one fetched instruction for the decode stage.
- Applies stall, branch and trap redirects, and flushes or discards stale fetches.

---
 rtl/if_fetch_ctrl_pkg.sv | 29 ++
 rtl/if_fetch_ctrl_if.sv | 14 +
 rtl/if_fetch_ctrl_instr_buf.sv | 70 +++++++
 rtl/if_fetch_ctrl.sv | 143 ++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types and constants for the IF-stage fetch sequencer.
package if_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR          = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_ADDR_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP            = 32'h0000_0004;

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    FETCH = 3'd1,
    HOLD  = 3'd2,
    FLUSH = 3'd3,
    HALT  = 3'd4
  } fetch_state_e;

  // Trap wins over branch; the result is always word aligned.
  function automatic logic [XLEN-1:0] redirect_target(
    input logic            trap_valid,
    input logic [XLEN-1:0] trap_vector,
    input logic [XLEN-1:0] branch_target
  );
    logic [XLEN-1:0] sel;
    sel = trap_valid ? trap_vector : branch_target;
    return {sel[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Single-outstanding Wishbone-style instruction port.
interface if_fetch_ctrl_if #(
  parameter int XLEN = if_pkg::XLEN
);
  logic [XLEN-1:0] addr;
  logic            cyc;
  logic            stb;
  logic [XLEN-1:0] dat;
  logic            ack;
  logic            err;

  modport master (output addr, output cyc, output stb, input dat, input ack, input err);
  modport slave  (input addr, input cyc, input stb, output dat, output ack, output err);
endinterface

// File: rtl/if_fetch_ctrl_instr_buf.sv
// One-entry holding register for the fetched instruction handed to decode.
// Flush beats load, load beats accept. Fault, pc and instr only change on
// load or flush so they stay stable while decode is stalled.
module if_instr_buf
  import if_pkg::*;
#(
  parameter int              XLEN       = if_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_ADDR = if_pkg::RESET_ADDR_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] load_pc_i,
  input  logic [XLEN-1:0] load_instr_i,
  input  logic            load_fault_i,
  input  logic            accept_i,
  input  logic            flush_i,
  output logic            valid_o,
  output logic            fault_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o
);

  logic            valid_q, valid_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;

  // Next-entry selection: flush, then load, then consumption by decode
  always_comb begin
    valid_d = valid_q;
    fault_d = fault_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (flush_i) begin
      valid_d = 1'b0;
      fault_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      fault_d = load_fault_i;
      pc_d    = load_pc_i;
      instr_d = load_instr_i;
    end else if (accept_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Entry registers with asynchronous reset to an empty NOP slot
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      pc_q    <= RESET_ADDR;
      instr_q <= NOP_INSTR;
    end else begin
      valid_q <= valid_d;
      fault_q <= fault_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid_o = valid_q;
  assign fault_o = fault_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the fetch PC, issues one request at a time
// on the instruction port, and handles stall, branch/trap redirect and errors.
module if_fetch_ctrl #(
  parameter int              XLEN       = if_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_ADDR = if_pkg::RESET_ADDR_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   if_stall_i,
  input  logic                   branch_taken_i,
  input  logic [XLEN-1:0]        branch_target_i,
  input  logic                   trap_valid_i,
  input  logic [XLEN-1:0]        trap_vector_i,
  if_fetch_ctrl_if.master        iport,
  output logic [XLEN-1:0]        pc_o,
  output logic [XLEN-1:0]        instr_o,
  output logic                   instr_valid_o,
  output logic                   fetch_fault_o
);
  import if_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] tgt_q, tgt_d;

  logic            accept_s;
  logic            buf_free_s;
  logic            redirect_s;
  logic [XLEN-1:0] target_s;
  logic            done_s;
  logic            req_s;
  logic            buf_load_s;
  logic            buf_fault_s;
  logic            buf_flush_s;

  assign accept_s   = instr_valid_o & ~if_stall_i;
  assign buf_free_s = ~instr_valid_o | accept_s;
  assign redirect_s = trap_valid_i | branch_taken_i;
  assign target_s   = redirect_target(trap_valid_i, trap_vector_i, branch_target_i);
  assign done_s     = iport.ack | iport.err;

  // A request only starts while the buffer is free; once started the buffer
  // stays empty until ack/err, so stb and addr remain stable for the slave.
  // Next-state, fetch PC and buffer-control decode
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    tgt_d       = tgt_q;
    req_s       = 1'b0;
    buf_load_s  = 1'b0;
    buf_fault_s = 1'b0;
    buf_flush_s = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH, HOLD: begin
        req_s = buf_free_s;
        if (redirect_s) begin
          buf_flush_s = 1'b1;
          if (req_s && !done_s) begin
            state_d = FLUSH;
            tgt_d   = target_s;
          end else begin
            state_d    = FETCH;
            fetch_pc_d = target_s;
          end
        end else if (req_s && iport.ack) begin
          buf_load_s = 1'b1;
          fetch_pc_d = fetch_pc_q + PC_STEP;
          state_d    = accept_s ? FETCH : HOLD;
        end else if (req_s && iport.err) begin
          buf_load_s  = 1'b1;
          buf_fault_s = 1'b1;
          state_d     = HALT;
        end else if (!buf_free_s) begin
          state_d = HOLD;
        end else begin
          state_d = FETCH;
        end
      end
      FLUSH: begin
        req_s       = 1'b1;
        buf_flush_s = redirect_s;
        if (done_s) begin
          state_d    = FETCH;
          fetch_pc_d = redirect_s ? target_s : tgt_q;
        end else begin
          state_d = FLUSH;
          tgt_d   = redirect_s ? target_s : tgt_q;
        end
      end
      HALT: begin
        if (redirect_s) begin
          buf_flush_s = 1'b1;
          state_d     = FETCH;
          fetch_pc_d  = target_s;
        end else begin
          state_d = HALT;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State, fetch PC and pending-redirect target registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_ADDR;
      tgt_q      <= RESET_ADDR;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      tgt_q      <= tgt_d;
    end
  end

  assign iport.cyc  = req_s;
  assign iport.stb  = req_s;
  assign iport.addr = fetch_pc_q;

  if_instr_buf #(
    .XLEN       (XLEN),
    .RESET_ADDR (RESET_ADDR)
  ) u_buf (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .load_i       (buf_load_s),
    .load_pc_i    (fetch_pc_q),
    .load_instr_i (buf_fault_s ? NOP_INSTR : iport.dat),
    .load_fault_i (buf_fault_s),
    .accept_i     (accept_s),
    .flush_i      (buf_flush_s),
    .valid_o      (instr_valid_o),
    .fault_o      (fetch_fault_o),
    .pc_o         (pc_o),
    .instr_o      (instr_o)
  );

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with a configurable-latency slave model.
module tb_if_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic [31:0] br_tgt = 32'h0;
  logic        trap = 1'b0;
  logic [31:0] trap_vec = 32'h0;
  logic [31:0] pc_o, instr_o;
  logic        valid_o, fault_o;

  int          ack_delay = 0;
  int          wcnt = 0;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = 32'h0;
  logic        slv_rdy, slv_is_err;

  int n_checks = 0;
  int n_fail = 0;

  if_fetch_ctrl_if ifc ();

  if_fetch_ctrl dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .if_stall_i      (stall),
    .branch_taken_i  (br),
    .branch_target_i (br_tgt),
    .trap_valid_i    (trap),
    .trap_vector_i   (trap_vec),
    .iport           (ifc),
    .pc_o            (pc_o),
    .instr_o         (instr_o),
    .instr_valid_o   (valid_o),
    .fetch_fault_o   (fault_o)
  );

  always #5 clk = ~clk;

  // Slave: answers after ack_delay wait cycles; data encodes the address.
  assign slv_rdy    = ifc.stb && (wcnt >= ack_delay);
  assign slv_is_err = err_en && (ifc.addr == err_addr);
  assign ifc.ack    = slv_rdy && !slv_is_err;
  assign ifc.err    = slv_rdy && slv_is_err;
  assign ifc.dat    = 32'hC0DE_0000 | {16'h0000, ifc.addr[15:0]};

  always @(posedge clk) begin
    if (rst || !ifc.stb || ifc.ack || ifc.err) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_checks++;
    if ({ifc.cyc, ifc.stb, valid_o, fault_o} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctl: got cyc/stb/valid/fault=%b expected 0000", {ifc.cyc, ifc.stb, valid_o, fault_o});
    end
    n_checks++;
    if ({pc_o, instr_o, ifc.addr} !== {32'h0, NOP, 32'h0}) begin
      n_fail++; $display("FAIL reset_data: got pc=%h instr=%h addr=%h expected 0/%h/0", pc_o, instr_o, ifc.addr, NOP);
    end
  endtask

  task automatic test_stream();
    logic [31:0] p;
    rst = 1'b0;
    #1;
    n_checks++;
    if (ifc.stb !== 1'b0) begin n_fail++; $display("FAIL boot_no_stb: got stb=%b expected 0", ifc.stb); end
    tick();
    n_checks++;
    if ({ifc.stb, ifc.addr, valid_o} !== {1'b1, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL first_fetch: got stb=%b addr=%h valid=%b expected 1/0/0", ifc.stb, ifc.addr, valid_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      p = 32'(4 * i);
      n_checks++;
      if ({valid_o, pc_o, instr_o} !== {1'b1, p, 32'hC0DE_0000 | p}) begin
        n_fail++; $display("FAIL stream_buf%0d: got valid=%b pc=%h instr=%h expected 1/%h/%h", i, valid_o, pc_o, instr_o, p, 32'hC0DE_0000 | p);
      end
      n_checks++;
      if ({ifc.stb, ifc.addr} !== {1'b1, p + 32'h4}) begin
        n_fail++; $display("FAIL stream_req%0d: got stb=%b addr=%h expected 1/%h", i, ifc.stb, ifc.addr, p + 32'h4);
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    #1;
    n_checks++;
    if ({ifc.stb, pc_o} !== {1'b0, 32'h8}) begin
      n_fail++; $display("FAIL stall_drop: got stb=%b pc=%h expected 0/00000008", ifc.stb, pc_o);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({ifc.stb, valid_o, pc_o, instr_o} !== {1'b0, 1'b1, 32'h8, 32'hC0DE_0008}) begin
        n_fail++; $display("FAIL stall_hold%0d: got stb=%b valid=%b pc=%h instr=%h expected 0/1/8/c0de0008", i, ifc.stb, valid_o, pc_o, instr_o);
      end
    end
    tick();
    stall = 1'b0;
    #1;
    n_checks++;
    if ({ifc.stb, ifc.addr} !== {1'b1, 32'hC}) begin
      n_fail++; $display("FAIL stall_release: got stb=%b addr=%h expected 1/0000000c", ifc.stb, ifc.addr);
    end
    tick();
    n_checks++;
    if (pc_o !== 32'hC) begin n_fail++; $display("FAIL stall_next: got pc=%h expected 0000000c", pc_o); end
  endtask

  task automatic test_branch_flush();
    ack_delay = 2;
    br = 1'b1;
    br_tgt = 32'h0000_0101;
    #1;
    n_checks++;
    if ({ifc.stb, ifc.ack, ifc.addr} !== {1'b1, 1'b0, 32'h10}) begin
      n_fail++; $display("FAIL br_req: got stb=%b ack=%b addr=%h expected 1/0/10", ifc.stb, ifc.ack, ifc.addr);
    end
    tick();
    br = 1'b0;
    #1;
    n_checks++;
    if ({valid_o, ifc.stb, ifc.addr} !== {1'b0, 1'b1, 32'h10}) begin
      n_fail++; $display("FAIL flush_hold1: got valid=%b stb=%b addr=%h expected 0/1/10", valid_o, ifc.stb, ifc.addr);
    end
    tick();
    n_checks++;
    if ({valid_o, ifc.stb, ifc.ack, ifc.addr} !== {1'b0, 1'b1, 1'b1, 32'h10}) begin
      n_fail++; $display("FAIL flush_hold2: got valid=%b stb=%b ack=%b addr=%h expected 0/1/1/10", valid_o, ifc.stb, ifc.ack, ifc.addr);
    end
    tick();
    ack_delay = 0;
    #1;
    n_checks++;
    if ({valid_o, ifc.stb, ifc.addr} !== {1'b0, 1'b1, 32'h100}) begin
      n_fail++; $display("FAIL flush_target: got valid=%b stb=%b addr=%h expected 0/1/100", valid_o, ifc.stb, ifc.addr);
    end
    tick();
    n_checks++;
    if ({valid_o, pc_o, instr_o} !== {1'b1, 32'h100, 32'hC0DE_0100}) begin
      n_fail++; $display("FAIL flush_first: got valid=%b pc=%h instr=%h expected 1/100/c0de0100", valid_o, pc_o, instr_o);
    end
  endtask

  task automatic test_trap_priority();
    trap = 1'b1;
    trap_vec = 32'h0000_0202;
    br = 1'b1;
    br_tgt = 32'h0000_0100;
    tick();
    trap = 1'b0;
    br = 1'b0;
    #1;
    n_checks++;
    if ({valid_o, ifc.stb, ifc.addr} !== {1'b0, 1'b1, 32'h200}) begin
      n_fail++; $display("FAIL trap_prio: got valid=%b stb=%b addr=%h expected 0/1/200", valid_o, ifc.stb, ifc.addr);
    end
    tick();
    n_checks++;
    if ({valid_o, pc_o, instr_o} !== {1'b1, 32'h200, 32'hC0DE_0200}) begin
      n_fail++; $display("FAIL trap_load: got valid=%b pc=%h instr=%h expected 1/200/c0de0200", valid_o, pc_o, instr_o);
    end
  endtask

  task automatic test_fault();
    err_en = 1'b1;
    err_addr = 32'h0000_0208;
    tick();
    n_checks++;
    if ({pc_o, ifc.stb, ifc.err, ifc.addr} !== {32'h204, 1'b1, 1'b1, 32'h208}) begin
      n_fail++; $display("FAIL err_setup: got pc=%h stb=%b err=%b addr=%h expected 204/1/1/208", pc_o, ifc.stb, ifc.err, ifc.addr);
    end
    tick();
    n_checks++;
    if ({valid_o, fault_o, pc_o, instr_o, ifc.stb} !== {1'b1, 1'b1, 32'h208, NOP, 1'b0}) begin
      n_fail++; $display("FAIL err_marker: got valid=%b fault=%b pc=%h instr=%h stb=%b expected 1/1/208/%h/0", valid_o, fault_o, pc_o, instr_o, ifc.stb, NOP);
    end
    tick();
    n_checks++;
    if ({ifc.stb, fault_o, valid_o} !== 3'b010) begin
      n_fail++; $display("FAIL halt_idle: got stb/fault/valid=%b expected 010", {ifc.stb, fault_o, valid_o});
    end
    br = 1'b1;
    br_tgt = 32'h0000_0040;
    err_en = 1'b0;
    tick();
    br = 1'b0;
    #1;
    n_checks++;
    if ({fault_o, valid_o, ifc.stb, ifc.addr} !== {1'b0, 1'b0, 1'b1, 32'h40}) begin
      n_fail++; $display("FAIL halt_exit: got fault=%b valid=%b stb=%b addr=%h expected 0/0/1/40", fault_o, valid_o, ifc.stb, ifc.addr);
    end
    tick();
    n_checks++;
    if ({valid_o, pc_o} !== {1'b1, 32'h40}) begin
      n_fail++; $display("FAIL halt_refetch: got valid=%b pc=%h expected 1/40", valid_o, pc_o);
    end
  endtask

  task automatic test_reset_mid();
    ack_delay = 3;
    #1;
    n_checks++;
    if ({ifc.stb, ifc.ack, ifc.addr} !== {1'b1, 1'b0, 32'h44}) begin
      n_fail++; $display("FAIL rst_mid_req: got stb=%b ack=%b addr=%h expected 1/0/44", ifc.stb, ifc.ack, ifc.addr);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({ifc.cyc, ifc.stb, valid_o, fault_o, pc_o, instr_o, ifc.addr} !== {4'b0000, 32'h0, NOP, 32'h0}) begin
      n_fail++; $display("FAIL rst_mid_async: got cyc=%b stb=%b valid=%b fault=%b pc=%h instr=%h addr=%h expected 0/0/0/0/0/%h/0", ifc.cyc, ifc.stb, valid_o, fault_o, pc_o, instr_o, ifc.addr, NOP);
    end
    tick();
    tick();
    ack_delay = 0;
    rst = 1'b0;
    br = 1'b1;
    br_tgt = 32'h0000_0300;
    #1;
    n_checks++;
    if (ifc.stb !== 1'b0) begin n_fail++; $display("FAIL rst_boot: got stb=%b expected 0", ifc.stb); end
    tick();
    br = 1'b0;
    #1;
    n_checks++;
    if ({ifc.stb, ifc.addr, valid_o} !== {1'b1, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL boot_redirect_ignored: got stb=%b addr=%h valid=%b expected 1/0/0", ifc.stb, ifc.addr, valid_o);
    end
  endtask

  task automatic test_wrap_redirect();
    br = 1'b1;
    br_tgt = 32'hFFFF_FFFF;
    tick();
    br = 1'b0;
    #1;
    n_checks++;
    if ({valid_o, ifc.stb, ifc.addr} !== {1'b0, 1'b1, 32'hFFFF_FFFC}) begin
      n_fail++; $display("FAIL wrap_target: got valid=%b stb=%b addr=%h expected 0/1/fffffffc", valid_o, ifc.stb, ifc.addr);
    end
    tick();
    n_checks++;
    if ({pc_o, instr_o, ifc.stb, ifc.addr} !== {32'hFFFF_FFFC, 32'hC0DE_FFFC, 1'b1, 32'h0}) begin
      n_fail++; $display("FAIL wrap_pc: got pc=%h instr=%h stb=%b addr=%h expected fffffffc/c0defffc/1/0", pc_o, instr_o, ifc.stb, ifc.addr);
    end
    stall = 1'b1;
    #1;
    n_checks++;
    if (ifc.stb !== 1'b0) begin n_fail++; $display("FAIL wrap_stall: got stb=%b expected 0", ifc.stb); end
    br = 1'b1;
    br_tgt = 32'h0000_0080;
    tick();
    br = 1'b0;
    #1;
    n_checks++;
    if ({valid_o, ifc.stb, ifc.addr} !== {1'b0, 1'b1, 32'h80}) begin
      n_fail++; $display("FAIL redirect_beats_stall: got valid=%b stb=%b addr=%h expected 0/1/80", valid_o, ifc.stb, ifc.addr);
    end
    stall = 1'b0;
    tick();
    n_checks++;
    if ({valid_o, pc_o} !== {1'b1, 32'h80}) begin
      n_fail++; $display("FAIL redirect_load: got valid=%b pc=%h expected 1/80", valid_o, pc_o);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_branch_flush();
    test_trap_priority();
    test_fault();
    test_reset_mid();
    test_wrap_redirect();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
